// File: rtl/exec_pkg.sv
// Shared encodings for the execute datapath: ALU opcodes, PSR bit positions
// and the per-op flag-update masks.
package exec_pkg;

  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b1101;

  localparam int PSR_C = 0;
  localparam int PSR_F = 1;
  localparam int PSR_L = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;
  localparam int PSR_W = 5;

  typedef logic [PSR_W-1:0] flag_mask_t;

  // ADD touches only C and F; SUB/CMP rewrite the whole PSR.
  localparam flag_mask_t MASK_NONE = 5'b00000;
  localparam flag_mask_t MASK_ADD  = 5'b00011;
  localparam flag_mask_t MASK_SUB  = 5'b11111;

endpackage

// File: rtl/regfile_param.sv
// Register file: two combinational operand read ports, one debug read port,
// one synchronous write port; asynchronous reset clears every register.
module regfile_param
  import exec_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see the pre-write contents during a same-cycle write.
  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/exec_datapath.sv
// Two-stage execute datapath: stage 1 reads operands and runs the ALU,
// stage 2 holds the result until it commits to the regfile and PSR.
// Build option EXEC_BYPASS_EN: forward stage-2 results instead of stalling.
module exec_datapath
  import exec_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [AW-1:0]    rsrc,
  input  logic [AW-1:0]    rdest,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       psr,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Overflow of b - a.
  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] d);
    return (b[WIDTH-1] != a[WIDTH-1]) && (d[WIDTH-1] != b[WIDTH-1]);
  endfunction

  logic                    vld_p2, we_p2;
  logic [AW-1:0]           rdest_p2;
  logic [WIDTH-1:0]        result_p2;
  flag_mask_t              flags_p2, mask_p2, psr_q;

  logic [WIDTH-1:0]        rf_a_p1, rf_b_p1, opa_p1, opb_p1, res_p1;
  logic signed [WIDTH-1:0] sa_p1, sb_p1;
  logic [WIDTH:0]          sum_p1, diff_p1;
  flag_mask_t              flags_p1, mask_p1;
  logic                    we_p1;
  logic                    accept, commit;

  assign commit = vld_p2 && out_ready;
  assign accept = in_valid && in_ready;

  regfile_param #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (commit && we_p2),
    .waddr    (rdest_p2),
    .wdata    (result_p2),
    .raddr_a  (rsrc),
    .rdata_a  (rf_a_p1),
    .raddr_b  (rdest),
    .rdata_b  (rf_b_p1),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

`ifdef EXEC_BYPASS_EN
  logic fwd_a, fwd_b;
  // Accept with a full stage 2 implies it commits this cycle, so its result is current.
  assign fwd_a    = vld_p2 && we_p2 && (rdest_p2 == rsrc);
  assign fwd_b    = vld_p2 && we_p2 && (rdest_p2 == rdest);
  assign opa_p1   = use_imm ? imm : (fwd_a ? result_p2 : rf_a_p1);
  assign opb_p1   = fwd_b ? result_p2 : rf_b_p1;
  assign in_ready = !vld_p2 || out_ready;
`else
  logic hazard;
  assign hazard   = vld_p2 && we_p2 &&
                    ((!use_imm && (rdest_p2 == rsrc)) || (rdest_p2 == rdest));
  assign opa_p1   = use_imm ? imm : rf_a_p1;
  assign opb_p1   = rf_b_p1;
  assign in_ready = (!vld_p2 || out_ready) && !hazard;
`endif

  // ---- stage 1: ALU ----
  assign sa_p1 = $signed(opa_p1);
  assign sb_p1 = $signed(opb_p1);

  always_comb begin
    sum_p1   = {1'b0, opb_p1} + {1'b0, opa_p1};
    diff_p1  = {1'b0, opb_p1} - {1'b0, opa_p1};
    res_p1   = '0;
    flags_p1 = '0;
    mask_p1  = MASK_NONE;
    we_p1    = 1'b0;
    unique case (opcode)
      OP_AND: begin res_p1 = opb_p1 & opa_p1; we_p1 = 1'b1; end
      OP_OR:  begin res_p1 = opb_p1 | opa_p1; we_p1 = 1'b1; end
      OP_XOR: begin res_p1 = opb_p1 ^ opa_p1; we_p1 = 1'b1; end
      OP_MOV: begin res_p1 = opa_p1;          we_p1 = 1'b1; end
      OP_ADD: begin
        res_p1          = sum_p1[WIDTH-1:0];
        we_p1           = 1'b1;
        mask_p1         = MASK_ADD;
        flags_p1[PSR_C] = sum_p1[WIDTH];
        flags_p1[PSR_F] = add_ovf(sa_p1, sb_p1, $signed(sum_p1[WIDTH-1:0]));
      end
      OP_SUB, OP_CMP: begin
        res_p1          = diff_p1[WIDTH-1:0];
        we_p1           = (opcode == OP_SUB);
        mask_p1         = MASK_SUB;
        flags_p1[PSR_C] = diff_p1[WIDTH];
        flags_p1[PSR_L] = diff_p1[WIDTH];
        flags_p1[PSR_F] = sub_ovf(sa_p1, sb_p1, $signed(diff_p1[WIDTH-1:0]));
        flags_p1[PSR_N] = sb_p1 < sa_p1;
        flags_p1[PSR_Z] = opb_p1 == opa_p1;
      end
      default: ; // undefined opcodes retire as no-ops
    endcase
  end

  // ---- stage 2: hold until commit ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2    <= 1'b0;
      we_p2     <= 1'b0;
      rdest_p2  <= '0;
      result_p2 <= '0;
      flags_p2  <= '0;
      mask_p2   <= '0;
      psr_q     <= '0;
    end else begin
      if (accept) begin
        vld_p2    <= 1'b1;
        we_p2     <= we_p1;
        rdest_p2  <= rdest;
        result_p2 <= res_p1;
        flags_p2  <= flags_p1;
        mask_p2   <= mask_p1;
      end else if (commit) begin
        vld_p2    <= 1'b0;
      end
      if (commit) psr_q <= (psr_q & ~mask_p2) | (flags_p2 & mask_p2);
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;
  assign psr       = psr_q;

endmodule

// File: doc/exec_datapath.md
# exec_datapath

Parametrised execute datapath for the 16-bit processor. It replaces the loose register file, ALU-control and ALU trio with one pipelined block. It accepts one register-register or register-immediate ALU operation per cycle over a valid/ready handshake and computes the result and flags. It commits the result to the register file and the flags to a stored PSR one stage later, with output backpressure and read-after-write forwarding. It sits between instruction decode and the memory/branch logic.

## Interface
- WIDTH, 16, datapath and register width (>= 4)
- NREGS, 16, number of registers (power of two, >= 2); AW = $clog2(NREGS)
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  operation offered
- in_ready  output  1  operation accepted when in_valid && in_ready
- opcode  input  4  ALU op: AND 0001, OR 0010, XOR 0011, ADD 0101, SUB 1001, CMP 1011, MOV 1101
- rsrc  input  AW  source register address
- rdest  input  AW  destination register address, also second operand
- imm  input  WIDTH  immediate operand
- use_imm  input  1  replace Rsrc operand with imm
- out_valid  output  1  stage-2 result pending commit
- out_ready  input  1  downstream accepts; commit happens on out_valid && out_ready
- result  output  WIDTH  stage-2 result
- psr  output  5  committed flags {N,Z,L,F,C} = psr[4:0]
- dbg_addr  input  AW  debug read address (combinational read of committed register)
- dbg_data  output  WIDTH  debug read data

## Operation
- Stage 1 (accept): read Rsrc/Rdest, select operand A = use_imm ? imm : Rsrc, B = Rdest, compute result and flags combinationally, register into stage 2 with rdest, write-enable (0 for CMP) and flag-update mask.
- Stage 2 (commit): on out_valid && out_ready, write result to rdest (if enabled) and load psr per mask.
- Arithmetic: ADD = B + A; SUB/CMP = B - A; all modulo 2^WIDTH. MOV result = A. Logic ops bitwise.
- Flags: ADD: C = carry out, F = signed overflow. SUB/CMP: C = borrow (B < A unsigned), F = signed overflow, L = B < A unsigned, N = B < A signed, Z = (B == A). Logic ops and MOV leave psr unchanged.
- ADD updates C, F only; SUB updates C, F, L, N, Z; CMP updates L, N, Z, C, F and writes no register.
- Handshake: in_ready = !out_valid || out_ready (hazard-free case). Stage 2 holds result, result address and flags stable while out_valid && !out_ready.
- Forwarding: if stage 2 holds an enabled write to address X and stage 1 reads X, stage 1 uses the stage-2 result, not the regfile.
- Simultaneous accept and commit: both proceed in the same cycle; the new op sees forwarded data.
- Commit and dbg read of the same address in the same cycle: dbg_data returns the old value.
- Reset mid-operation: pending stage-2 op is discarded, not committed.

## Timing
- Reset values: all registers 0, psr 5'b0, out_valid 0, result 0, in_ready 1 (bypass build).
- Latency: accepted at edge N -> out_valid/result visible after edge N; commit at first edge with out_ready high, earliest N+1.
- Sustained throughput 1 op/cycle with out_ready held high.

## Configuration
- EXEC_BYPASS_EN defined: forwarding as above; no hazard stalls.
- Undefined: no forwarding. in_ready is forced low while stage 2 holds an enabled write whose address matches rsrc (when !use_imm) or rdest, so a dependent op costs one extra cycle after commit.

## Structure
- Package exec_pkg: opcode localparams, PSR bit indices (PSR_C=0, PSR_F=1, PSR_L=2, PSR_Z=3, PSR_N=4), flag-mask typedef.
- Sub-module regfile_param (WIDTH, NREGS): 2 combinational read ports, 1 debug read port, 1 synchronous write port, async reset.
- ALU is combinational logic inside exec_datapath.

## Test plan
- Reset with NREGS=16 -> all dbg_data 0, psr 0, out_valid 0.
- MOV imm 16'h000A to r3, then ADD r3,r3 back-to-back, out_ready=1 -> r3 = 16'h0014 (forwarded), psr C=0 F=0.
- r1=FFFF, r2=0001, ADD rsrc=r1 rdest=r2 -> result 0000, C=1. r1=7FFF, r2=0004, ADD -> result 8003, F=1.
- CMP rsrc=r1 (0001) rdest=r2 (FFFF) -> L=0, N=1, Z=0, r2 unchanged. Equal values -> Z=1.
- out_ready low for 3 cycles with two ops issued -> second op stalled, result stable, no commit; release -> commits in order.
- EXEC_BYPASS_EN undefined: dependent ADD after write to r2 -> in_ready low 1 cycle, correct final value. Reset asserted while out_valid -> target register unchanged.
